spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clkgen.sv | 41 ++++
 rtl/spi_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding and frame phase lengths.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ADDR  = 3'd2,
        TURN  = 3'd3,
        DATA  = 3'd4,
        TAIL  = 3'd5,
        DONE  = 3'd6
    } spi_state_t;

    localparam int HDR_BITS  = 8;
    localparam int DATA_BITS = 8;

    // Reads carry an all-zero data byte so mosi stays low through TURN/DATA.
    function automatic logic [15:0] frame_word(
        input logic [6:0] a,
        input logic       r,
        input logic [7:0] d
    );
        return {a, r, (r ? 8'h00 : d)};
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// sclk divider: half-period ticks, registered sclk, rise/fall slot strobes.
module spi_clkgen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] RELOAD = 8'(HALF_DIV - 1);

    logic [7:0] div_cnt;
    logic       tick;

    assign tick = run && (div_cnt == 8'd0);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    // en only gates the rising edge, so a suppressed rise still ends a phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= RELOAD;
            sclk    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == 8'd0) ? RELOAD : div_cnt - 8'd1;
            if (rise && en) begin
                sclk <= 1'b1;
            end else if (fall) begin
                sclk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master: SETUP/ADDR/TURN/DATA/TAIL/DONE frame sequencer.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 2,
    parameter int TURN_CYC = 3,
    parameter int TAIL_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       miso,
    output logic       sclk_out,
    output logic       cs,
    output logic       mosi,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    spi_state_t  state;
    logic        run;
    logic        rw_q;
    logic        rise;
    logic        fall;
    logic        sclk_en;
    logic        phase_end;
    logic        in_frame;
    logic        to_data;
    logic        sample;
    logic [3:0]  bit_cnt;
    logic [3:0]  phase_len;
    logic [15:0] shreg;
    logic [7:0]  rx;

    spi_clkgen #(
        .HALF_DIV(HALF_DIV)
    ) u_clkgen (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .en   (sclk_en),
        .sclk (sclk_out),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        phase_len = 4'd0;
        unique case (state)
            ADDR:    phase_len = 4'(HDR_BITS);
            TURN:    phase_len = 4'(TURN_CYC);
            DATA:    phase_len = 4'(DATA_BITS);
            TAIL:    phase_len = 4'(TAIL_CYC);
            default: phase_len = 4'd0;
        endcase
    end

    // Phases end on the rise slot after their last full cycle.
    assign in_frame  = state inside {ADDR, TURN, DATA, TAIL};
    assign phase_end = rise && (bit_cnt == phase_len);
    assign sclk_en   = !(state == TAIL && bit_cnt == 4'(TAIL_CYC));
    assign to_data   = phase_end &&
                       ((state == ADDR && !rw_q) || state == TURN);
    assign sample    = to_data || (rise && state == DATA && !phase_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            run     <= 1'b0;
            rw_q    <= 1'b0;
            bit_cnt <= 4'd0;
            shreg   <= 16'h0000;
            rx      <= 8'h00;
        end else begin
            done <= 1'b0;
            if (sample) begin
                rx <= {rx[6:0], miso};
            end
            if (fall && in_frame) begin
                shreg   <= {shreg[14:0], 1'b0};
                mosi    <= shreg[14];
                bit_cnt <= bit_cnt + 4'd1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        cs      <= 1'b0;
                        run     <= 1'b1;
                        rw_q    <= rw;
                        shreg   <= frame_word(addr, rw, wdata);
                        mosi    <= addr[6];
                        bit_cnt <= 4'd0;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        state   <= ADDR;
                        bit_cnt <= 4'd0;
                    end
                end
                ADDR: begin
                    if (phase_end) begin
                        state   <= rw_q ? TURN : DATA;
                        bit_cnt <= 4'd0;
                    end
                end
                TURN: begin
                    if (phase_end) begin
                        state   <= DATA;
                        bit_cnt <= 4'd0;
                    end
                end
                DATA: begin
                    if (phase_end) begin
                        state   <= TAIL;
                        bit_cnt <= 4'd0;
                    end
                end
                TAIL: begin
                    if (phase_end) begin
                        state   <= DONE;
                        bit_cnt <= 4'd0;
                        cs      <= 1'b1;
                        done    <= 1'b1;
                        run     <= 1'b0;
                        if (rw_q) begin
                            rdata <= rx;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
